// File: rtl/arm_pipelined_cond_unit.sv
// arm_pipelined_cond_unit: Execute-stage NZCV flag register, condition check and control gating
module arm_pipelined_cond_unit #(
  parameter int FlagWidth = 4,
  parameter int CondWidth = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  input  logic                 i_Valid_E,
  input  logic                 i_Stall_E,
  input  logic [CondWidth-1:0] i_Cond_E,
  input  logic [FlagWidth-1:0] i_ALU_Flags,
  input  logic [1:0]           i_Flag_Write_E,
  input  logic                 i_Reg_Write_E,
  input  logic                 i_Mem_Write_E,
  input  logic                 i_PC_Src_E,
  input  logic                 i_Branch_E,
  output logic                 o_Cond_Ex,
  output logic                 o_Reg_Write,
  output logic                 o_Mem_Write,
  output logic                 o_PC_Src,
  output logic                 o_Branch_Taken,
  output logic [FlagWidth-1:0] o_Flags
);
  logic [FlagWidth-1:0] flags;
  logic n, z, c, v, base, pass;
  assign {n, z, c, v} = flags;
  // odd condition codes are the complement of the even code below them; AL/NV pair this way too
  always_comb begin
    base = i_Cond_E[3:1] == 3'd0 ? z :
           i_Cond_E[3:1] == 3'd1 ? c :
           i_Cond_E[3:1] == 3'd2 ? n :
           i_Cond_E[3:1] == 3'd3 ? v :
           i_Cond_E[3:1] == 3'd4 ? c & !z :
           i_Cond_E[3:1] == 3'd5 ? n == v :
           i_Cond_E[3:1] == 3'd6 ? !z & (n == v) : 1'b1;
    pass = base ^ i_Cond_E[0];
  end
  assign o_Cond_Ex      = pass & i_Valid_E;
  assign o_Reg_Write    = i_Reg_Write_E & o_Cond_Ex;
  assign o_Mem_Write    = i_Mem_Write_E & o_Cond_Ex;
  assign o_PC_Src       = i_PC_Src_E & o_Cond_Ex;
  assign o_Branch_Taken = i_Branch_E & o_Cond_Ex;
  assign o_Flags        = flags;
  // commit N,Z and C,V halves independently for executing, unstalled instructions
  always_ff @(posedge i_CLK) begin
    if (i_RESET) flags <= '0;
    else if (!i_Stall_E && o_Cond_Ex) begin
      if (i_Flag_Write_E[1]) flags[3:2] <= i_ALU_Flags[3:2];
      if (i_Flag_Write_E[0]) flags[1:0] <= i_ALU_Flags[1:0];
    end
  end
endmodule

// File: tb/tb_arm_pipelined_cond_unit.sv
// tb_arm_pipelined_cond_unit: scoreboard bench against a spec-level flag/condition model
module tb_arm_pipelined_cond_unit;
  logic clk = 0;
  logic rst = 0, valid = 0, stall = 0, rw = 0, mw = 0, pc = 0, br = 0;
  logic [3:0] cond = 0, alu = 0, flags_o;
  logic [1:0] fw = 0;
  logic cex_o, rw_o, mw_o, pc_o, br_o;
  int checks = 0, passed = 0;
  logic [8:0] sb[$];
  logic [3:0] mf;
  bit known = 0;

  arm_pipelined_cond_unit dut (
    .i_CLK(clk), .i_RESET(rst), .i_Valid_E(valid), .i_Stall_E(stall),
    .i_Cond_E(cond), .i_ALU_Flags(alu), .i_Flag_Write_E(fw),
    .i_Reg_Write_E(rw), .i_Mem_Write_E(mw), .i_PC_Src_E(pc), .i_Branch_E(br),
    .o_Cond_Ex(cex_o), .o_Reg_Write(rw_o), .o_Mem_Write(mw_o), .o_PC_Src(pc_o),
    .o_Branch_Taken(br_o), .o_Flags(flags_o));

  always #5 clk = ~clk;

  function automatic bit cond_pass(input logic [3:0] cc, input logic [3:0] f);
    bit nf, zf, cf, vf;
    {nf, zf, cf, vf} = f;
    case (cc)
      4'd0: return zf;
      4'd1: return !zf;
      4'd2: return cf;
      4'd3: return !cf;
      4'd4: return nf;
      4'd5: return !nf;
      4'd6: return vf;
      4'd7: return !vf;
      4'd8: return cf && !zf;
      4'd9: return !cf || zf;
      4'd10: return nf == vf;
      4'd11: return nf != vf;
      4'd12: return !zf && nf == vf;
      4'd13: return zf || nf != vf;
      4'd14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit r, input bit va, input bit st, input logic [3:0] cc,
                      input logic [3:0] a, input logic [1:0] w, input bit prw, input bit pmw,
                      input bit ppc, input bit pbr);
    bit ex;
    rst = r; valid = va; stall = st; cond = cc; alu = a; fw = w;
    rw = prw; mw = pmw; pc = ppc; br = pbr;
    ex = va && cond_pass(cc, mf);
    if (known) sb.push_back({ex, prw && ex, pmw && ex, ppc && ex, pbr && ex, mf});
    @(posedge clk);
    #1;
    if (r) begin
      mf = 4'b0000;
      known = 1;
    end else if (known && ex && !st) begin
      if (w[1]) mf[3:2] = a[3:2];
      if (w[0]) mf[1:0] = a[1:0];
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // monitor: every mid-cycle sample compares against the oldest pending expectation
  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      logic [8:0] e;
      e = sb.pop_front();
      chk("cond_ex", {3'b0, cex_o}, {3'b0, e[8]});
      chk("reg_write", {3'b0, rw_o}, {3'b0, e[7]});
      chk("mem_write", {3'b0, mw_o}, {3'b0, e[6]});
      chk("pc_src", {3'b0, pc_o}, {3'b0, e[5]});
      chk("branch_taken", {3'b0, br_o}, {3'b0, e[4]});
      chk("flags", flags_o, e[3:0]);
    end
  end

  initial begin
    #1;
    step(1, 0, 0, 4'he, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 4'he, 4'b1111, 2'b11, 1, 1, 1, 1);
    // 1: AL writes flags 0100
    step(0, 1, 0, 4'he, 4'b0100, 2'b11, 1, 0, 0, 0);
    // 2: sweep all conditions with F=0100
    for (int i = 0; i < 16; i++) step(0, 1, 0, i[3:0], 4'b1111, 2'b00, 1, 1, 1, 1);
    // 3: F=0000, EQ fails, no commit
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 4'h0, 4'b1111, 2'b11, 0, 1, 0, 0);
    step(0, 1, 0, 4'he, 0, 0, 0, 0, 0, 0);
    // 4: partial updates from F=1010
    step(0, 1, 0, 4'he, 4'b1010, 2'b11, 0, 0, 0, 0);
    step(0, 1, 0, 4'he, 4'b0101, 2'b10, 0, 0, 0, 0);
    step(0, 1, 0, 4'he, 4'b1001, 2'b01, 0, 0, 0, 0);
    step(0, 1, 0, 4'he, 0, 0, 0, 0, 0, 0);
    // 5: stall then bubble
    step(0, 1, 1, 4'he, 4'b1000, 2'b11, 1, 0, 0, 0);
    step(0, 0, 0, 4'he, 4'b1000, 2'b11, 1, 1, 1, 1);
    step(0, 1, 0, 4'he, 0, 0, 0, 0, 0, 0);
    // 6: CMP then BNE, twice; then reset against a flag-setting AL
    step(0, 1, 0, 4'he, 4'b0110, 2'b11, 0, 0, 0, 0);
    step(0, 1, 0, 4'h1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 4'he, 4'b0010, 2'b11, 0, 0, 0, 0);
    step(0, 1, 0, 4'h1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 4'he, 4'b1111, 2'b11, 1, 0, 0, 0);
    step(0, 1, 0, 4'he, 0, 0, 0, 0, 0, 0);
    // randomized traffic, including reset during stall
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
           4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
